k2_prog_loader: RTL

K2_PROG_LOADER -- requirements
Module: k2_prog_loader

---
 rtl/k2_prog_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/k2_prog_loader.sv
// Program loader: accepts a length-prefixed byte stream into instruction memory,
// then releases the CPU. Define K2_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module k2_prog_loader #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] cpu_addr,
  output logic [7:0] cpu_instr,
  output logic       cpu_reset_n,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] dbg_state
);

  localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  // Byte stream handshake: a byte moves on a rising edge where in_valid and
  // in_ready are both 1; in_ready depends only on state, never on in_valid.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
`ifdef K2_LOADER_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_RUN  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] mem_q [DEPTH];
  logic       cpu_reset_n_q;
  logic       we;
  logic       xfer;
  logic       loading;
`ifdef K2_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  always_comb begin
    loading = 1'b0;
    case (state_q)
      S_HDR, S_LOAD: loading = 1'b1;
`ifdef K2_LOADER_CHECKSUM_EN
      S_CHK:         loading = 1'b1;
`endif
      default:       loading = 1'b0;
    endcase
  end

  assign xfer = in_valid & loading;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    we      = 1'b0;
`ifdef K2_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) state_d = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          count_d = in_data;
          addr_d  = 8'd0;
`ifdef K2_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
          if (in_data == 8'd0 || {1'b0, in_data} > DEPTH9) state_d = S_ERR;
          else                                             state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          we     = 1'b1;
          addr_d = addr_q + 8'd1;
`ifdef K2_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
          if (addr_q == count_q - 8'd1) state_d = S_CHK;
`else
          if (addr_q == count_q - 8'd1) state_d = S_RUN;
`endif
        end
      end
`ifdef K2_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (8'(sum_q + in_data) == 8'd0) state_d = S_RUN;
          else                             state_d = S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      count_q       <= 8'd0;
      addr_q        <= 8'd0;
      cpu_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      addr_q        <= addr_d;
      // Registered from next state so the CPU reset tracks RUN exactly.
      cpu_reset_n_q <= (state_d == S_RUN);
    end
  end

`ifdef K2_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= 8'd0;
    else          sum_q <= sum_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we) begin
      mem_q[addr_q[AW-1:0]] <= in_data;
    end
  end

  assign cpu_instr   = ({1'b0, cpu_addr} < DEPTH9) ? mem_q[cpu_addr[AW-1:0]] : 8'h00;
  assign in_ready    = loading;
  assign busy        = loading;
  assign done        = (state_q == S_RUN);
  assign error       = (state_q == S_ERR);
  assign cpu_reset_n = cpu_reset_n_q;
  assign dbg_state   = state_q;

endmodule
